label_bitmap_packer: RTL and testbench
======================================

// Module: label_bitmap_packer
// PURPOSE
// - Read-back end of the labelling path: scans the 1024-entry label SRAM written by the labeller and re-packs it into a 128-byte binary bitmap.
// - Uses the same bit layout as the input image ROM, so the bitmap can be compared against the source image or reloaded.
// - Reports the foreground pixel count.
// - Sits after the labeller; owns the SRAM read port while busy.
// PARAMETERS
// IMG_W   32  image width in pixels
// IMG_H   32  image height in pixels
// LBL_W   8   label width in bits (SRAM data width)
// PARAMETERS (derived)
// - PIX = IMG_W*IMG_H = 1024.
// - Byte count = PIX/8 = 128.
// PORTS
// clk        in   1   single clock, rising edge
// reset      in   1   synchronous, active-low reset
// start      in   1   one-cycle request to begin a scan; sampled in IDLE or DONE
// sram_q     in   8   label read data; registered SRAM, valid the cycle after sram_a holds the address
// sram_a     out  10  label SRAM read address
// out_a      out  7   bitmap byte address
// out_d      out  8   bitmap byte data
// out_wen    out  1   bitmap write enable, active-low, one cycle per byte
// fg_count   out  11  foreground pixel count (0..1024); valid when finish=1
// busy       out  1   high from the start-accepting edge until finish rises
// finish     out  1   high when the scan is complete; held until the next accepted start
// BEHAVIOUR
// - Reset (reset=0 at a clock edge), from any state including mid-scan:
//   - state=IDLE, sram_a=0, out_a=0, out_d=0, out_wen=1, fg_count=0, busy=0, finish=0.
//   - The partial byte is discarded; no write is issued.
// - FSM states:
//   - IDLE -start-> READ
//   - READ -(last address issued)-> DRAIN
//   - DRAIN -(last byte written)-> DONE
//   - DONE -start-> READ (clears finish and fg_count)
// - READ: edge E0 accepts start and registers sram_a=0. sram_a then increments by 1 every edge up to 1023; no stalls.
// - Capture: data for address p is sampled at the edge two edges after the edge that loaded p into sram_a.
//   - Pixel bit = (sram_q != 0); any nonzero label (including 8'hFF) counts as foreground.
// - Packing: pixel p goes to bit (p%8) of byte p/8.
//   - When bit 7 is captured, the next cycle drives out_a=p/8, out_d=byte, out_wen=0 for exactly one cycle.
//   - The accumulator clears for the next byte.
// - fg_count increments by 1 for each captured foreground bit. It is 11 bits wide, so 1024 does not wrap.
// - Timing: the last write (out_a=127) occurs in the cycle after edge E0+1025. finish=1 and busy=0 from edge E0+1026.
// - start while busy=1: ignored. start and reset together: reset wins.
// - Outputs are registered; no combinational input-to-output paths.
// CONFIGURATION
// - Macro LABEL_SEL_EN.
// - Defined:
//   - Adds input port sel_label [7:0], sampled at the start-accepting edge and held for the whole scan.
//   - If sel_label != 0, pixel bit = (sram_q == sel_label). fg_count then counts only that label.
//   - If sel_label == 0, behaviour matches the undefined case.
// - Undefined: no sel_label port; pixel bit = (sram_q != 0).
// STRUCTURE
// - Shared package cle_pkg holds:
//   - IMG_W, IMG_H, PIX, BYTES, LBL_W constants.
//   - The FSM state enum (IDLE, READ, DRAIN, DONE).
//   - ROM/SRAM address width constants (7, 10).
// - One sub-module, bit_packer: 8-bit LSB-first shift accumulator with a byte_valid pulse and a 3-bit bit index.
// - Top level holds the FSM, the address counter, the read-data pipeline alignment and fg_count.
// TESTING
// - All-zero SRAM, start -> 128 writes with out_d=8'h00; out_a runs 0..127 in order; fg_count=0; finish rises at E0+1026.
// - All-labels-3 SRAM -> every out_d=8'hFF; fg_count=1024 (no wrap); busy falls in the same cycle finish rises.
// - Single nonzero at address 9 (label 8'hFF) -> only out_a=1 gets out_d=8'h02; every other byte is 0; fg_count=1.
// - Checkerboard labels (1 at even addresses) -> every out_d=8'h55; fg_count=512.
// - Reset pulsed low at E0+500 -> all outputs return to reset values next cycle. A new start then gives a full, correct 128-byte scan.
// - LABEL_SEL_EN, SRAM filled with labels 1 and 2 alternating, sel_label=2 -> every out_d=8'hAA; fg_count=512.
//   - Same SRAM, sel_label=0 -> every out_d=8'hFF.
// - start pulsed while busy -> ignored; write sequence and timing unchanged.

Source files
------------

// File: rtl/cle_pkg.sv
// Shared constants, FSM state type and pixel rule for the label read-back path.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cle_pkg;

  localparam int IMG_W   = 32;
  localparam int IMG_H   = 32;
  localparam int PIX     = IMG_W * IMG_H;
  localparam int BYTES   = PIX / 8;
  localparam int LBL_W   = 8;
  localparam int ROM_AW  = 7;
  localparam int SRAM_AW = 10;
  localparam int CNT_W   = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // A zero selector means "any nonzero label is foreground".
  function automatic logic pixel_of(input logic [LBL_W-1:0] q,
                                    input logic [LBL_W-1:0] sel);
    return (sel == '0) ? (q != '0) : (q == sel);
  endfunction

endpackage

// File: rtl/label_bitmap_packer_bit_packer.sv
// bit_packer: LSB-first 8-bit accumulator, emits a registered byte with its index.
// Latency: byte output registered on the edge that captures its bit 7.
// Backpressure: none; accepts one bit per cycle whenever bit_vld is high.
module bit_packer
  import cle_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              bit_vld,
  input  logic              bit_dat,
  output logic              byte_vld,
  output logic [7:0]        byte_dat,
  output logic [ROM_AW-1:0] byte_a,
  output logic [2:0]        bit_idx
);

  logic [6:0]        acc;
  logic [ROM_AW-1:0] byte_cnt;

  // Shift bits in LSB-first; on the eighth bit emit the full byte and restart.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc      <= '0;
      bit_idx  <= '0;
      byte_cnt <= '0;
      byte_vld <= 1'b0;
      byte_dat <= '0;
      byte_a   <= '0;
    end else begin
      byte_vld <= 1'b0;
      if (clr) begin
        acc      <= '0;
        bit_idx  <= '0;
        byte_cnt <= '0;
      end else if (bit_vld) begin
        if (bit_idx == 3'd7) begin
          byte_vld <= 1'b1;
          byte_dat <= {bit_dat, acc};
          byte_a   <= byte_cnt;
          byte_cnt <= byte_cnt + 7'd1;
          acc      <= '0;
          bit_idx  <= '0;
        end else begin
          acc     <= {bit_dat, acc[6:1]};
          bit_idx <= bit_idx + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/label_bitmap_packer.sv
// label_bitmap_packer: scans the 1024-entry label SRAM and writes a 128-byte bitmap.
// Latency: last byte written in the cycle after E0+1025, finish from E0+1026.
// Backpressure: none; start ignored while busy. Optional macro LABEL_SEL_EN adds sel_label.
module label_bitmap_packer
  import cle_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
`ifdef LABEL_SEL_EN
  input  logic [LBL_W-1:0]   sel_label,
`endif
  input  logic [LBL_W-1:0]   sram_q,
  output logic [SRAM_AW-1:0] sram_a,
  output logic [ROM_AW-1:0]  out_a,
  output logic [7:0]         out_d,
  output logic               out_wen,
  output logic [CNT_W-1:0]   fg_count,
  output logic               busy,
  output logic               finish
);

  state_t      state;
  logic        cap_vld;
  logic        pix_bit;
  logic        accept;
  logic        byte_vld;
  logic [2:0]  bit_idx;

  assign accept = start && ((state == IDLE) || (state == DONE));

`ifdef LABEL_SEL_EN
  logic [LBL_W-1:0] sel_q;

  // Selector is frozen for the whole scan at the accepting edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sel_q <= '0;
    end else if (accept) begin
      sel_q <= sel_label;
    end
  end

  assign pix_bit = pixel_of(sram_q, sel_q);
`else
  assign pix_bit = pixel_of(sram_q, '0);
`endif

  // Scan FSM: address issue, read-data alignment and completion handshake.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      sram_a  <= '0;
      busy    <= 1'b0;
      finish  <= 1'b0;
      cap_vld <= 1'b0;
    end else begin
      // Address held in READ this cycle reaches sram_q one cycle later.
      cap_vld <= (state == READ);
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state  <= READ;
            sram_a <= '0;
            busy   <= 1'b1;
            finish <= 1'b0;
          end
        end
        READ: begin
          if (sram_a == SRAM_AW'(PIX - 1)) begin
            state <= DRAIN;
          end else begin
            sram_a <= sram_a + 10'd1;
          end
        end
        DRAIN: begin
          if (byte_vld && (out_a == ROM_AW'(BYTES - 1)) && (bit_idx == 3'd0)) begin
            state  <= DONE;
            busy   <= 1'b0;
            finish <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Foreground count; 11 bits so a fully set image reads 1024.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fg_count <= '0;
    end else if (accept) begin
      fg_count <= '0;
    end else if (cap_vld && pix_bit) begin
      fg_count <= fg_count + 11'd1;
    end
  end

  bit_packer u_bit_packer (
    .clk      (clk),
    .reset    (reset),
    .clr      (accept),
    .bit_vld  (cap_vld),
    .bit_dat  (pix_bit),
    .byte_vld (byte_vld),
    .byte_dat (out_d),
    .byte_a   (out_a),
    .bit_idx  (bit_idx)
  );

  assign out_wen = ~byte_vld;

endmodule

// File: tb/tb_label_bitmap_packer.sv
module tb_label_bitmap_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  sram_q;
  logic [9:0]  sram_a;
  logic [6:0]  out_a;
  logic [7:0]  out_d;
  logic        out_wen;
  logic [10:0] fg_count;
  logic        busy;
  logic        finish;
`ifdef LABEL_SEL_EN
  logic [7:0]  sel_label = 8'd0;
`endif

  logic [7:0] mem [1024];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Registered SRAM model.
  always @(posedge clk) sram_q <= mem[sram_a];

  label_bitmap_packer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
`ifdef LABEL_SEL_EN
    .sel_label(sel_label),
`endif
    .sram_q   (sram_q),
    .sram_a   (sram_a),
    .out_a    (out_a),
    .out_d    (out_d),
    .out_wen  (out_wen),
    .fg_count (fg_count),
    .busy     (busy),
    .finish   (finish)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sram_a"}, 32'(sram_a), 0);
    check({tag, "_out_a"}, 32'(out_a), 0);
    check({tag, "_out_d"}, 32'(out_d), 0);
    check({tag, "_out_wen"}, 32'(out_wen), 1);
    check({tag, "_fg"}, 32'(fg_count), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_finish"}, 32'(finish), 0);
  endtask

  // 0 zero, 1 all 3, 2 single FF at 9, 3 checker, 4 dense random, 5 sparse random, 6 alt 1/2
  task automatic fill(input int mode);
    for (int a = 0; a < 1024; a++) begin
      case (mode)
        0: mem[a] = 8'd0;
        1: mem[a] = 8'd3;
        2: mem[a] = (a == 9) ? 8'hFF : 8'h00;
        3: mem[a] = (a % 2 == 0) ? 8'd1 : 8'd0;
        4: mem[a] = 8'($urandom_range(0, 255));
        5: mem[a] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
        default: mem[a] = (a % 2 == 0) ? 8'd1 : 8'd2;
      endcase
    end
  endtask

  // One scan checked against a bitmap computed straight from mem.
  // glitch_k: cycle (after E0) at which to pulse start; abort_k: cycle to apply reset.
  task automatic run_scan(input int sel, input int glitch_k, input int abort_k);
    logic [7:0] expb [128];
    int expfg;
    int nw;
    int k;
    logic b;
    expfg = 0;
    for (int by = 0; by < 128; by++) begin
      expb[by] = 8'd0;
      for (int i = 0; i < 8; i++) begin
        b = (sel == 0) ? (mem[by*8+i] != 8'd0) : (mem[by*8+i] == 8'(sel));
        expb[by][i] = b;
        expfg += int'(b);
      end
    end
    @(negedge clk);
    start = 1'b1;
`ifdef LABEL_SEL_EN
    sel_label = 8'(sel);
`endif
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 0;
    nw = 0;
    check("e0_sram_a", 32'(sram_a), 0);
    check("e0_busy", 32'(busy), 1);
    check("e0_finish", 32'(finish), 0);
    while (!finish && k < 1200) begin
      start = (k == glitch_k);
      if (abort_k > 0 && k == abort_k - 1) reset = 1'b0;
      @(posedge clk);
      #1;
      k++;
      if (abort_k > 0 && k == abort_k) begin
        check_reset_vals("abort");
        reset = 1'b1;
        start = 1'b0;
        return;
      end
      if (!out_wen) begin
        if (nw < 128) begin
          check("wr_addr", 32'(out_a), 32'(nw));
          check("wr_data", 32'(out_d), 32'(expb[nw]));
        end else begin
          check("extra_wr", 32'(nw), 127);
        end
        nw++;
      end
      if (k == 1023) check("sram_a_last", 32'(sram_a), 1023);
      if (k == 1025) begin
        check("last_wr_count", 32'(nw), 128);
        check("pre_fin_busy", 32'(busy), 1);
        check("pre_fin_finish", 32'(finish), 0);
      end
    end
    start = 1'b0;
    check("finish_cycle", 32'(k), 1026);
    check("fin_busy", 32'(busy), 0);
    check("fin_count", 32'(fg_count), 32'(expfg));
    check("num_writes", 32'(nw), 128);
    // finish must hold while idle.
    repeat (3) @(posedge clk);
    #1;
    check("finish_hold", 32'(finish), 1);
    check("idle_wen", 32'(out_wen), 1);
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("init");
    reset = 1'b1;
    repeat (2) @(posedge clk);

    fill(0); run_scan(0, -1, 0);
    fill(1); run_scan(0, -1, 0);
    fill(2); run_scan(0, -1, 0);
    fill(3); run_scan(0, -1, 0);
    fill(4); run_scan(0, -1, 500);
    run_scan(0, -1, 0);
    fill(5); run_scan(0, 300, 0);
    fill(4); run_scan(0, 5, 0);
`ifdef LABEL_SEL_EN
    fill(6); run_scan(2, -1, 0);
    run_scan(0, -1, 0);
    fill(4); run_scan($urandom_range(1, 255), -1, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
